// File: rtl/cpu_loader.sv
// Host-side loader in front of the cpu: loads imem/dmem, runs the cpu for N cycles, dumps dmem.
// Optional macro CPU_LOADER_CHECKSUM_EN adds an XOR checksum word after each load.
module cpu_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              cpu_enable,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    DUMP_RD   = 3'd3,
    DUMP_WAIT = 3'd4,
    DUMP_OUT  = 3'd5
`ifdef CPU_LOADER_CHECKSUM_EN
    ,CHK      = 3'd6
`endif
  } state_t;

  localparam logic [7:0]  LAT_LAST = 8'(RD_LAT - 1);
  localparam logic [31:0] STEP32   = 32'(ADDR_STEP);

  state_t              state_r, state_s;
  logic                is_data_r, is_data_s;
  logic [13:0]         base_r, base_s;
  logic [15:0]         cnt_r, cnt_s;
  logic [15:0]         idx_r, idx_s;
  logic [7:0]          lat_r, lat_s;
  logic                out_valid_r, out_valid_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic                err_r, err_s;
`ifdef CPU_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   xor_r, xor_s;
`endif

  logic                ready_s;
  logic                load_wr_s;
  logic                ren_s;
  logic                run_s;
  logic                last_s;
  logic [15:0]         word_idx_s;
  logic [31:0]         addr_s;

  // Word index wraps in 16 bits before being scaled to a byte address
  assign word_idx_s = {2'b00, base_r} + idx_r;
  assign addr_s     = {16'd0, word_idx_s} * STEP32;
  assign last_s     = (idx_r == (cnt_r - 16'd1));

  // Next-state, datapath next values and decoded strobes
  always_comb begin
    state_s     = state_r;
    is_data_s   = is_data_r;
    base_s      = base_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    lat_s       = lat_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    err_s       = err_r;
`ifdef CPU_LOADER_CHECKSUM_EN
    xor_s       = xor_r;
`endif
    ready_s     = 1'b0;
    load_wr_s   = 1'b0;
    ren_s       = 1'b0;
    run_s       = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (in_valid && (in_data[15:0] != 16'd0)) begin
          base_s    = in_data[29:16];
          cnt_s     = in_data[15:0];
          idx_s     = 16'd0;
          is_data_s = in_data[30];
`ifdef CPU_LOADER_CHECKSUM_EN
          xor_s     = {DATA_W{1'b0}};
`endif
          case (in_data[31:30])
            2'b00, 2'b01: state_s = LOAD;
            2'b10:        state_s = RUN;
            2'b11:        state_s = DUMP_RD;
            default:      state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        ready_s = 1'b1;
        if (in_valid) begin
          load_wr_s = 1'b1;
`ifdef CPU_LOADER_CHECKSUM_EN
          xor_s     = xor_r ^ in_data;
`endif
          if (last_s) begin
            idx_s = 16'd0;
`ifdef CPU_LOADER_CHECKSUM_EN
            state_s = CHK;
`else
            state_s = IDLE;
`endif
          end else begin
            idx_s = idx_r + 16'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      RUN: begin
        run_s = 1'b1;
        // A word offered while the cpu runs is a protocol error; it waits for IDLE
        if (in_valid) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        if (last_s) begin
          idx_s   = 16'd0;
          state_s = IDLE;
        end else begin
          idx_s = idx_r + 16'd1;
        end
      end
      DUMP_RD: begin
        ren_s   = 1'b1;
        lat_s   = 8'd0;
        state_s = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (lat_r == LAT_LAST) begin
          out_data_s  = rdata_ext_2;
          out_valid_s = 1'b1;
          state_s     = DUMP_OUT;
        end else begin
          lat_s = lat_r + 8'd1;
        end
      end
      DUMP_OUT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          if (({1'b0, idx_r} + 17'd1) < {1'b0, cnt_r}) begin
            idx_s   = idx_r + 16'd1;
            state_s = DUMP_RD;
          end else begin
            idx_s   = 16'd0;
            state_s = IDLE;
          end
        end else begin
          out_valid_s = 1'b1;
        end
      end
`ifdef CPU_LOADER_CHECKSUM_EN
      CHK: begin
        ready_s = 1'b1;
        if (in_valid) begin
          if (in_data != xor_r) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          state_s = IDLE;
        end else begin
          state_s = CHK;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command context, counters, dump output and sticky error
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      is_data_r   <= 1'b0;
      base_r      <= 14'd0;
      cnt_r       <= 16'd0;
      idx_r       <= 16'd0;
      lat_r       <= 8'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
      xor_r       <= {DATA_W{1'b0}};
`endif
    end else begin
      is_data_r   <= is_data_s;
      base_r      <= base_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      lat_r       <= lat_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      err_r       <= err_s;
`ifdef CPU_LOADER_CHECKSUM_EN
      xor_r       <= xor_s;
`endif
    end
  end

  // Write strobes coincide with the accepting cycle of each payload word
  assign wen_ext     = load_wr_s & ~is_data_r;
  assign wen_ext_2   = load_wr_s & is_data_r;
  assign ren_ext_2   = ren_s;
  assign ren_ext     = 1'b0;
  assign addr_ext    = wen_ext ? addr_s : 32'd0;
  assign wdata_ext   = wen_ext ? in_data : {DATA_W{1'b0}};
  assign addr_ext_2  = (wen_ext_2 | ren_s) ? addr_s : 32'd0;
  assign wdata_ext_2 = wen_ext_2 ? in_data : {DATA_W{1'b0}};
  assign cpu_enable  = run_s;
  assign in_ready    = ready_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign busy        = (state_r != IDLE);
  assign err         = err_r;

endmodule
